// File: rtl/char_ram_arb_pkg.sv
// Shared types and widths for the character RAM arbiter.
package char_ram_arb_pkg;

    localparam int unsigned NumReq = 2;
    localparam int unsigned AdrW   = 12;
    localparam int unsigned DatW   = 32;
    localparam int unsigned SelW   = 4;
    localparam int unsigned CntW   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        ACK  = 2'd3
    } state_e;

    typedef struct packed {
        logic            we;
        logic [SelW-1:0] sel;
        logic [AdrW-1:0] adr;
        logic [DatW-1:0] dat;
    } bus_req_t;

endpackage

// File: rtl/char_ram_rr_pick.sv
// Round-robin winner select between two requesters with a last-grant register.
module char_ram_rr_pick
    import char_ram_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              take_i,
    output logic [NumReq-1:0] win_c_o
);

    logic last_q;
    logic last_d;

    // Contested cycle goes to whoever was not granted last; a sole requester always wins.
    always_comb begin
        win_c_o = req_i;
        if (req_i[0] && req_i[1]) begin
            win_c_o = last_q ? NumReq'(2'b01) : NumReq'(2'b10);
        end
    end

    always_comb begin
        last_d = last_q;
        if (take_i) begin
            last_d = win_c_o[1];
        end
    end

    // Resets to requester 1 so requester 0 wins the first contested cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/char_ram_arbiter.sv
// Two-requester round-robin arbiter for the character RAM port A.
module char_ram_arbiter
    import char_ram_arb_pkg::*;
#(
    parameter int unsigned pReadLatency = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [SelW-1:0]   m0_sel_i,
    input  logic [AdrW-1:0]   m0_adr_i,
    input  logic [DatW-1:0]   m0_dat_i,
    output logic              m0_ack_o,
    output logic [DatW-1:0]   m0_dat_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [SelW-1:0]   m1_sel_i,
    input  logic [AdrW-1:0]   m1_adr_i,
    input  logic [DatW-1:0]   m1_dat_i,
    output logic              m1_ack_o,
    output logic [DatW-1:0]   m1_dat_o,
    output logic              ram_cs_o,
    output logic              ram_we_o,
    output logic [SelW-1:0]   ram_sel_o,
    output logic [AdrW-1:0]   ram_adr_o,
    output logic [DatW-1:0]   ram_dat_o,
    input  logic [DatW-1:0]   ram_dat_i,
    output logic              busy_o,
    output logic [NumReq-1:0] grant_o
);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_we_q, ram_we_d;
    logic [SelW-1:0]     ram_sel_q, ram_sel_d;
    logic [AdrW-1:0]     ram_adr_q, ram_adr_d;
    logic [DatW-1:0]     ram_dat_q, ram_dat_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [NumReq-1:0]   ack_q, ack_d;
    logic [DatW-1:0]     rdat_q [NumReq];
    logic [DatW-1:0]     rdat_d [NumReq];
    logic                busy_q, busy_d;

    logic [NumReq-1:0]   req;
    logic [NumReq-1:0]   win;
    logic                take;
    bus_req_t            pl0, pl1, win_pl;

    assign req    = {m1_req_i, m0_req_i};
    assign pl0    = '{we: m0_we_i, sel: m0_sel_i, adr: m0_adr_i, dat: m0_dat_i};
    assign pl1    = '{we: m1_we_i, sel: m1_sel_i, adr: m1_adr_i, dat: m1_dat_i};
    assign win_pl = win[1] ? pl1 : pl0;

    char_ram_rr_pick u_pick (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req),
        .take_i  (take),
        .win_c_o (win)
    );

    // Next-state and registered-output decode; RAM strobes follow the state being entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_cs_d  = 1'b0;
        ram_we_d  = 1'b0;
        ram_sel_d = '0;
        ram_adr_d = ram_adr_q;
        ram_dat_d = ram_dat_q;
        grant_d   = grant_q;
        ack_d     = '0;
        busy_d    = 1'b0;
        take      = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            rdat_d[i] = '0;
        end

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    take      = 1'b1;
                    grant_d   = win;
                    busy_d    = 1'b1;
                    ram_cs_d  = 1'b1;
                    ram_adr_d = win_pl.adr;
                    ram_dat_d = win_pl.dat;
                    cnt_d     = '0;
                    if (win_pl.we) begin
                        state_d   = WR;
                        ram_we_d  = 1'b1;
                        ram_sel_d = win_pl.sel;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                state_d = ACK;
                ack_d   = grant_q;
                busy_d  = 1'b1;
            end
            RD: begin
                busy_d = 1'b1;
                if (cnt_q == CntW'(pReadLatency - 1)) begin
                    state_d = ACK;
                    ack_d   = grant_q;
                    for (int i = 0; i < int'(NumReq); i++) begin
                        rdat_d[i] = grant_q[i] ? ram_dat_i : '0;
                    end
                end else begin
                    cnt_d    = cnt_q + CntW'(1);
                    ram_cs_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ram_cs_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_sel_q <= '0;
            ram_adr_q <= '0;
            ram_dat_q <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < int'(NumReq); i++) begin
                rdat_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ram_cs_q  <= ram_cs_d;
            ram_we_q  <= ram_we_d;
            ram_sel_q <= ram_sel_d;
            ram_adr_q <= ram_adr_d;
            ram_dat_q <= ram_dat_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            for (int i = 0; i < int'(NumReq); i++) begin
                rdat_q[i] <= rdat_d[i];
            end
        end
    end

    assign m0_ack_o  = ack_q[0];
    assign m1_ack_o  = ack_q[1];
    assign m0_dat_o  = rdat_q[0];
    assign m1_dat_o  = rdat_q[1];
    assign ram_cs_o  = ram_cs_q;
    assign ram_we_o  = ram_we_q;
    assign ram_sel_o = ram_sel_q;
    assign ram_adr_o = ram_adr_q;
    assign ram_dat_o = ram_dat_q;
    assign busy_o    = busy_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed bench for char_ram_arbiter: default latency-2 instance plus a latency-4 instance.
module tb_char_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          errors = 0;
    int          checks = 0;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [11:0] m0_adr, m1_adr;
    logic [31:0] m0_dat, m1_dat;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_dato, m1_dato;
    logic        ram_cs, ram_we, busy;
    logic [3:0]  ram_sel;
    logic [11:0] ram_adr;
    logic [31:0] ram_wdat, ram_rdat;
    logic [1:0]  grant;

    logic        q_req;
    logic [11:0] q_adr;
    logic        q_ack0, q_ack1, q_cs, q_we, q_busy;
    logic [31:0] q_dato0, q_dato1, q_wdat, q_rdat;
    logic [3:0]  q_sel;
    logic [11:0] q_radr;
    logic [1:0]  q_grant;

    int          cs_cnt = 0;
    int          q_cs_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_val(input logic [11:0] a);
        return (a == 12'h020) ? 32'h1234_5678 : {20'hCAFE0, a};
    endfunction

    // RAM model: data is only valid in the final cycle of a read of the configured latency.
    always_ff @(posedge clk) cs_cnt   <= ram_cs ? cs_cnt + 1 : 0;
    always_ff @(posedge clk) q_cs_cnt <= q_cs ? q_cs_cnt + 1 : 0;
    assign ram_rdat = (ram_cs && cs_cnt == 1)   ? ram_val(ram_adr) : 32'hBAD0_BAD0;
    assign q_rdat   = (q_cs   && q_cs_cnt == 3) ? ram_val(q_radr)  : 32'hBAD0_BAD0;

    char_ram_arbiter u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_ack_o(m0_ack), .m0_dat_o(m0_dato),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_ack_o(m1_ack), .m1_dat_o(m1_dato),
        .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_adr_o(ram_adr),
        .ram_dat_o(ram_wdat), .ram_dat_i(ram_rdat), .busy_o(busy), .grant_o(grant)
    );

    char_ram_arbiter #(.pReadLatency(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(q_req), .m0_we_i(1'b0), .m0_sel_i(4'hF), .m0_adr_i(q_adr), .m0_dat_i(32'h0),
        .m0_ack_o(q_ack0), .m0_dat_o(q_dato0),
        .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_sel_i(4'h0), .m1_adr_i(12'h0), .m1_dat_i(32'h0),
        .m1_ack_o(q_ack1), .m1_dat_o(q_dato1),
        .ram_cs_o(q_cs), .ram_we_o(q_we), .ram_sel_o(q_sel), .ram_adr_o(q_radr),
        .ram_dat_o(q_wdat), .ram_dat_i(q_rdat), .busy_o(q_busy), .grant_o(q_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [1:0] ack_seq [6];
    logic [1:0] gnt_seq [6];
    int         n;

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dat = 0;
        m1_req = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dat = 0;
        q_req = 0; q_adr = 0;
        for (int i = 0; i < 6; i++) begin
            ack_seq[i] = 2'b00;
            gnt_seq[i] = 2'b00;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_cs", 32'(ram_cs), 0);
        chk("rst_acks", 32'({m1_ack, m0_ack}), 0);
        rst_n = 1'b1;

        // m0 write
        @(negedge clk);
        m0_req = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 12'h010; m0_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_c1_cs", 32'(ram_cs), 1);
        chk("wr_c1_we", 32'(ram_we), 1);
        chk("wr_c1_sel", 32'(ram_sel), 32'hF);
        chk("wr_c1_adr", 32'(ram_adr), 32'h010);
        chk("wr_c1_dat", ram_wdat, 32'hDEAD_BEEF);
        chk("wr_c1_grant", 32'(grant), 1);
        chk("wr_c1_busy", 32'(busy), 1);
        chk("wr_c1_ack", 32'(m0_ack), 0);
        @(negedge clk);
        chk("wr_c2_ack", 32'({m1_ack, m0_ack}), 32'b01);
        chk("wr_c2_cs", 32'(ram_cs), 0);
        m0_req = 0;
        @(negedge clk);
        chk("wr_c3_ack", 32'(m0_ack), 0);
        chk("wr_c3_busy", 32'(busy), 0);

        // m1 read, latency 2
        m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_adr = 12'h020;
        @(negedge clk);
        chk("rd_c1_cs", 32'(ram_cs), 1);
        chk("rd_c1_we", 32'(ram_we), 0);
        chk("rd_c1_sel", 32'(ram_sel), 0);
        chk("rd_c1_grant", 32'(grant), 32'b10);
        @(negedge clk);
        chk("rd_c2_cs", 32'(ram_cs), 1);
        chk("rd_c2_ack", 32'(m1_ack), 0);
        @(negedge clk);
        chk("rd_c3_ack", 32'({m1_ack, m0_ack}), 32'b10);
        chk("rd_c3_m1dat", m1_dato, 32'h1234_5678);
        chk("rd_c3_m0dat", m0_dato, 0);
        chk("rd_c3_cs", 32'(ram_cs), 0);
        m1_req = 0;
        @(negedge clk);
        chk("rd_c4_ack", 32'(m1_ack), 0);
        chk("rd_c4_m1dat", m1_dato, 0);

        // both request continuously for six transactions
        m0_req = 1; m0_we = 1; m0_sel = 4'h3; m0_adr = 12'h100; m0_dat = 32'h1111_1111;
        m1_req = 1; m1_we = 1; m1_sel = 4'hC; m1_adr = 12'h200; m1_dat = 32'h2222_2222;
        n = 0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            @(negedge clk);
            chk("rr_no_dual_ack", 32'(m0_ack & m1_ack), 0);
            if (m0_ack || m1_ack) begin
                ack_seq[n] = {m1_ack, m0_ack};
                gnt_seq[n] = grant;
                n++;
            end
        end
        m0_req = 0; m1_req = 0;
        chk("rr_count", 32'(n), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_ack_%0d", i), 32'(ack_seq[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
            chk($sformatf("rr_gnt_%0d", i), 32'(gnt_seq[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
        end
        @(negedge clk);
        chk("rr_idle_busy", 32'(busy), 0);

        // m0 read, reset during first RD cycle
        m0_req = 1; m0_we = 0; m0_adr = 12'h020;
        @(negedge clk);
        chk("rst_rd_c1_cs", 32'(ram_cs), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rd_cs", 32'(ram_cs), 0);
        chk("rst_rd_busy", 32'(busy), 0);
        chk("rst_rd_grant", 32'(grant), 0);
        @(negedge clk);
        chk("rst_rd_acks", 32'({m1_ack, m0_ack}), 0);
        chk("rst_rd_dat", m0_dato, 0);
        rst_n = 1'b1;
        m0_we = 1; m0_sel = 4'h1; m1_req = 1; m1_we = 1;
        @(negedge clk);
        chk("post_rst_grant", 32'(grant), 32'b01);
        @(negedge clk);
        chk("post_rst_ack", 32'({m1_ack, m0_ack}), 32'b01);
        m0_req = 0; m1_req = 0;
        @(negedge clk);

        // m0 write with no byte lanes
        m0_req = 1; m0_we = 1; m0_sel = 4'h0; m0_adr = 12'h040; m0_dat = 32'h5555_AAAA;
        @(negedge clk);
        chk("sel0_c1_cs", 32'(ram_cs), 1);
        chk("sel0_c1_we", 32'(ram_we), 1);
        chk("sel0_c1_sel", 32'(ram_sel), 0);
        @(negedge clk);
        chk("sel0_c2_we", 32'(ram_we), 0);
        chk("sel0_c2_ack", 32'(m0_ack), 1);
        m0_req = 0;
        @(negedge clk);

        // latency-4 instance, m0 read
        q_req = 1; q_adr = 12'h030;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("l4_c%0d_cs", c), 32'(q_cs), 1);
            chk($sformatf("l4_c%0d_ack", c), 32'(q_ack0), 0);
        end
        @(negedge clk);
        chk("l4_c5_ack", 32'(q_ack0), 1);
        chk("l4_c5_dat", q_dato0, 32'hCAFE_0030);
        chk("l4_c5_cs", 32'(q_cs), 0);
        chk("l4_m1_ack", 32'(q_ack1), 0);
        q_req = 0;
        @(negedge clk);
        chk("l4_c6_ack", 32'(q_ack0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
